// File: rtl/fish_pkg.sv
// Shared types and constants for the fishing-scene tick sequencer:
// scheduler states, per-level fish geometry and reel rise-rate thresholds.
package fish_pkg;

    typedef enum logic [1:0] {
        ST_ARM    = 2'd0,
        ST_SWIM   = 2'd1,
        ST_HOOKED = 2'd2,
        ST_WIN    = 2'd3
    } state_t;

    typedef struct packed {
        logic [9:0] y;
        logic [5:0] w;
        logic [3:0] hh;
        logic [3:0] window;
    } level_geom_t;

    localparam level_geom_t LEVEL0_GEOM = '{y: 10'd470, w: 6'd60, hh: 4'd10, window: 4'd15};
    localparam level_geom_t LEVEL1_GEOM = '{y: 10'd380, w: 6'd40, hh: 4'd8,  window: 4'd10};
    localparam level_geom_t LEVEL2_GEOM = '{y: 10'd290, w: 6'd20, hh: 4'd5,  window: 4'd5};
    localparam level_geom_t LEVEL3_GEOM = '{y: 10'd200, w: 6'd10, hh: 4'd3,  window: 4'd3};

    localparam logic [1:0] LAST_LEVEL       = 2'd3;
    localparam logic [3:0] REEL_RATE_THRESH = 4'd9;

    localparam int ARM_TICKS_DEFAULT = 400;
    localparam int SWIM_STEP_DEFAULT = 2;
    localparam int X_START_DEFAULT   = 798;
    localparam int X_END_DEFAULT     = 144;
    localparam int SURFACE_Y_DEFAULT = 106;

    // Fast reeling lifts the line two pixels, exactly-threshold reeling one.
    function automatic logic [1:0] rise_rate(input logic [3:0] r);
        if (r > REEL_RATE_THRESH)
            return 2'd2;
        else if (r == REEL_RATE_THRESH)
            return 2'd1;
        else
            return 2'd0;
    endfunction

endpackage

// File: rtl/fish_level_rom.sv
// Level geometry lookup: level index to fish y, width, half-height and
// the horizontal catch window.
module fish_level_rom
    import fish_pkg::*;
(
    input  logic [1:0]  level,
    output level_geom_t geom
);

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        geom = LEVEL0_GEOM;
        case (level)
            2'd1:    geom = LEVEL1_GEOM;
            2'd2:    geom = LEVEL2_GEOM;
            2'd3:    geom = LEVEL3_GEOM;
            default: geom = LEVEL0_GEOM;
        endcase
    end

endmodule

// File: rtl/fish_scheduler.sv
// Game-tick sequencer: arms and launches each fish, sweeps it across the
// water, detects the hook catch, reels it up and steps through the levels.
module fish_scheduler
    import fish_pkg::*;
#(
    parameter int ARM_TICKS = ARM_TICKS_DEFAULT,
    parameter int SWIM_STEP = SWIM_STEP_DEFAULT,
    parameter int X_START   = X_START_DEFAULT,
    parameter int X_END     = X_END_DEFAULT,
    parameter int SURFACE_Y = SURFACE_Y_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move,
    input  logic       grab,
    input  logic [8:0] reel,
    input  logic [9:0] hook_x,
    input  logic [9:0] hook_y,
    output logic [9:0] fxpos,
    output logic [9:0] fypos,
    output logic [5:0] fish_w,
    output logic [3:0] fish_hh,
    output logic [1:0] level,
    output logic       fish_vis,
    output logic       hooked,
    output logic [1:0] reel_dy,
    output logic       win
);

    localparam int CNT_W = $clog2(ARM_TICKS + 1);

    localparam logic [CNT_W-1:0] ARM_LIMIT = CNT_W'(ARM_TICKS);
    localparam logic [9:0]       X_START_V = 10'(X_START);
    localparam logic [9:0]       X_END_V   = 10'(X_END);
    localparam logic [9:0]       STEP_V    = 10'(SWIM_STEP);
    localparam logic [9:0]       SURFACE_V = 10'(SURFACE_Y);
    localparam logic [9:0]       Y_RESET   = LEVEL0_GEOM.y;

    state_t           state;
    logic [CNT_W-1:0] arm_cnt;

    level_geom_t geom;
    level_geom_t geom_next;

    fish_level_rom u_rom_cur (
        .level (level),
        .geom  (geom)
    );

    fish_level_rom u_rom_next (
        .level (level + 2'd1),
        .geom  (geom_next)
    );

    assign fish_w  = geom.w;
    assign fish_hh = geom.hh;

    // Bounds widened to 11 bits so the upper edges never wrap; the lower y edge floors at 0.
    logic [10:0] x_hi;
    logic [10:0] y_hi;
    logic [9:0]  y_lo;
    logic        catch_hit;
    logic [1:0]  rate;

    always_comb begin
        x_hi      = {1'b0, fxpos} + {7'd0, geom.window};
        y_hi      = {1'b0, fypos} + {7'd0, geom.hh};
        y_lo      = (fypos >= {6'd0, geom.hh}) ? (fypos - {6'd0, geom.hh}) : 10'd0;
        catch_hit = grab
                 && (hook_x >= fxpos) && ({1'b0, hook_x} <= x_hi)
                 && (hook_y >= y_lo)  && ({1'b0, hook_y} <= y_hi);
        rate      = rise_rate(reel[8:5]);
    end

    logic unused_bits;
    assign unused_bits = ^{reel[4:0], geom_next.w, geom_next.hh, geom_next.window};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_ARM;
            level    <= 2'd0;
            arm_cnt  <= '0;
            fxpos    <= X_START_V;
            fypos    <= Y_RESET;
            fish_vis <= 1'b0;
            hooked   <= 1'b0;
            reel_dy  <= 2'd0;
            win      <= 1'b0;
        end else begin
            case (state)
                ST_ARM: begin
                    fxpos <= X_START_V;
                    fypos <= geom.y;
                    if (move && arm_cnt != ARM_LIMIT)
                        arm_cnt <= arm_cnt + CNT_W'(1);
                    if (arm_cnt == ARM_LIMIT) begin
                        state    <= ST_SWIM;
                        fish_vis <= 1'b1;
                    end
                end

                ST_SWIM: begin
                    if (catch_hit) begin
                        state  <= ST_HOOKED;
                        hooked <= 1'b1;
                        fxpos  <= hook_x;
                    end else if (fxpos == X_END_V) begin
                        state    <= ST_ARM;
                        fish_vis <= 1'b0;
                        fxpos    <= X_START_V;
                        arm_cnt  <= '0;
                    end else begin
                        fxpos <= fxpos - STEP_V;
                    end
                end

                ST_HOOKED: begin
                    // Landing tests the pre-decrement y, so one extra rise lands past the surface.
                    if (fypos < SURFACE_V) begin
                        hooked   <= 1'b0;
                        fish_vis <= 1'b0;
                        reel_dy  <= 2'd0;
                        if (level != LAST_LEVEL) begin
                            state   <= ST_ARM;
                            level   <= level + 2'd1;
                            fxpos   <= X_START_V;
                            fypos   <= geom_next.y;
                            arm_cnt <= '0;
                        end else begin
                            state <= ST_WIN;
                            win   <= 1'b1;
                        end
                    end else begin
                        fxpos   <= hook_x;
                        fypos   <= fypos - {8'd0, rate};
                        reel_dy <= rate;
                    end
                end

                ST_WIN: begin
                    if (move) begin
                        state   <= ST_ARM;
                        win     <= 1'b0;
                        level   <= 2'd0;
                        fxpos   <= X_START_V;
                        fypos   <= Y_RESET;
                        arm_cnt <= '0;
                    end
                end

                default: state <= ST_ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_fish_scheduler.sv
// Self-checking bench for fish_scheduler: directed tables and sequences plus
// randomized play, all compared every tick against a rule-level game model.
module tb_fish_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       move;
    logic       grab;
    logic [8:0] reel;
    logic [9:0] hook_x;
    logic [9:0] hook_y;
    logic [9:0] fxpos;
    logic [9:0] fypos;
    logic [5:0] fish_w;
    logic [3:0] fish_hh;
    logic [1:0] level;
    logic       fish_vis;
    logic       hooked;
    logic [1:0] reel_dy;
    logic       win;

    always #5 clk = ~clk;

    fish_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .move     (move),
        .grab     (grab),
        .reel     (reel),
        .hook_x   (hook_x),
        .hook_y   (hook_y),
        .fxpos    (fxpos),
        .fypos    (fypos),
        .fish_w   (fish_w),
        .fish_hh  (fish_hh),
        .level    (level),
        .fish_vis (fish_vis),
        .hooked   (hooked),
        .reel_dy  (reel_dy),
        .win      (win)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- game model: phases and level table as plain integers
    localparam int P_ARM = 0, P_SWIM = 1, P_HOOKED = 2, P_WIN = 3;
    localparam int LY[4]  = '{470, 380, 290, 200};
    localparam int LW[4]  = '{60, 40, 20, 10};
    localparam int LHH[4] = '{10, 8, 5, 3};
    localparam int LWIN[4] = '{15, 10, 5, 3};

    int m_phase, m_lvl, m_moves, m_x, m_y, m_dy;

    task automatic model_reset();
        m_phase = P_ARM;
        m_lvl   = 0;
        m_moves = 0;
        m_x     = 798;
        m_y     = 470;
        m_dy    = 0;
    endtask

    task automatic model_step();
        int speed;
        int ylo;
        speed = 0;
        case (m_phase)
            P_ARM: begin
                m_x = 798;
                m_y = LY[m_lvl];
                if (m_moves >= 400) m_phase = P_SWIM;
                else if (move) m_moves = m_moves + 1;
            end
            P_SWIM: begin
                ylo = (m_y > LHH[m_lvl]) ? m_y - LHH[m_lvl] : 0;
                if (grab && int'(hook_x) >= m_x && int'(hook_x) <= m_x + LWIN[m_lvl]
                         && int'(hook_y) >= ylo && int'(hook_y) <= m_y + LHH[m_lvl]) begin
                    m_phase = P_HOOKED;
                    m_x = int'(hook_x);
                end else if (m_x == 144) begin
                    m_phase = P_ARM;
                    m_x = 798;
                    m_moves = 0;
                end else begin
                    m_x = m_x - 2;
                end
            end
            P_HOOKED: begin
                if (int'(reel) / 32 > 9) speed = 2;
                else if (int'(reel) / 32 == 9) speed = 1;
                if (m_y < 106) begin
                    if (m_lvl < 3) begin
                        m_lvl = m_lvl + 1;
                        m_x = 798;
                        m_y = LY[m_lvl];
                        m_moves = 0;
                        m_phase = P_ARM;
                    end else begin
                        m_phase = P_WIN;
                    end
                end else begin
                    m_x = int'(hook_x);
                    m_y = m_y - speed;
                end
            end
            default: begin
                if (move) begin
                    m_phase = P_ARM;
                    m_lvl = 0;
                    m_x = 798;
                    m_y = 470;
                    m_moves = 0;
                end
            end
        endcase
        m_dy = (m_phase == P_HOOKED) ? speed : 0;
    endtask

    function automatic logic [31:0] model_status();
        logic vis;
        vis = (m_phase == P_SWIM) || (m_phase == P_HOOKED);
        return {15'd0, 2'(m_lvl), vis, 1'(m_phase == P_HOOKED), 1'(m_phase == P_WIN),
                2'(m_dy), 6'(LW[m_lvl]), 4'(LHH[m_lvl])};
    endfunction

    task automatic compare_model();
        check("fxpos", 32'(fxpos), 32'(m_x));
        check("fypos", 32'(fypos), 32'(m_y));
        check("status", {15'd0, level, fish_vis, hooked, win, reel_dy, fish_w, fish_hh}, model_status());
    endtask

    // One game tick; inputs are changed by callers only after this returns (edge + 1).
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_fxpos"}, 32'(fxpos), 32'd798);
        check({tag, "_fypos"}, 32'(fypos), 32'd470);
        check({tag, "_flags"}, {25'd0, level, fish_vis, hooked, win, reel_dy}, 32'd0);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        check_reset_values(tag);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic launch();
        move = 1'b1;
        grab = 1'b0;
        repeat (400) tick();
        check("arm_hold", 32'(fish_vis), 32'd0);
        tick();
        check("launch_vis", 32'(fish_vis), 32'd1);
        check("launch_x", 32'(fxpos), 32'd798);
        move = 1'b0;
    endtask

    task automatic catch_now();
        hook_x = 10'(m_x);
        hook_y = 10'(m_y);
        grab = 1'b1;
        tick();
        check("catch_now", 32'(hooked), 32'd1);
        grab = 1'b0;
    endtask

    task automatic rise_until_landed();
        int budget;
        reel = {4'd12, 5'd7};
        budget = 400;
        while (hooked && budget > 0) begin
            hook_x = 10'($urandom_range(200, 700));
            tick();
            budget--;
        end
        check("land_timeout", 32'(hooked), 32'd0);
    endtask

    typedef struct {
        int dx;
        int dy;
        bit exp_hooked;
    } catch_vec_t;

    typedef struct {
        logic [3:0] nib;
        int         exp_dy;
    } reel_vec_t;

    catch_vec_t catch_tab[5];
    reel_vec_t  reel_tab[5];

    initial begin
        int budget;
        int y_before;

        catch_tab[0] = '{dx: 16, dy: -5,  exp_hooked: 1'b0};
        catch_tab[1] = '{dx: -1, dy: 0,   exp_hooked: 1'b0};
        catch_tab[2] = '{dx: 5,  dy: -11, exp_hooked: 1'b0};
        catch_tab[3] = '{dx: 5,  dy: 11,  exp_hooked: 1'b0};
        catch_tab[4] = '{dx: 15, dy: 10,  exp_hooked: 1'b1};
        reel_tab[0]  = '{nib: 4'd10, exp_dy: 2};
        reel_tab[1]  = '{nib: 4'd9,  exp_dy: 1};
        reel_tab[2]  = '{nib: 4'd8,  exp_dy: 0};
        reel_tab[3]  = '{nib: 4'd15, exp_dy: 2};
        reel_tab[4]  = '{nib: 4'd0,  exp_dy: 0};

        rst = 1'b1; move = 1'b0; grab = 1'b0; reel = '0; hook_x = '0; hook_y = '0;
        model_reset();
        #2;
        check_reset_values("reset");
        #1;
        rst = 1'b0;

        // Arm for 400 moves, launch on the next tick, then sweep left.
        launch();
        tick();
        check("swim_step", 32'(fxpos), 32'd796);

        budget = 400;
        while (fxpos != 10'd144 && budget > 0) begin
            tick();
            budget--;
        end
        check("reach_x_end", 32'(fxpos), 32'd144);
        tick();
        check("wrap_x", 32'(fxpos), 32'd798);
        check("wrap_vis", 32'(fish_vis), 32'd0);

        // Re-arm from a cleared count, swim to x=500 and run the catch window table.
        launch();
        budget = 400;
        while (m_x != 500 && budget > 0) begin
            tick();
            budget--;
        end
        check("reach_500", 32'(fxpos), 32'd500);
        for (int i = 0; i < 5; i++) begin
            hook_x = 10'(m_x + catch_tab[i].dx);
            hook_y = 10'(m_y + catch_tab[i].dy);
            grab = 1'b1;
            tick();
            check($sformatf("catch_%0d", i), 32'(hooked), 32'(catch_tab[i].exp_hooked));
        end
        check("hook_follow_x", 32'(fxpos), 32'd507);
        grab = 1'b0;

        for (int i = 0; i < 5; i++) begin
            reel = {reel_tab[i].nib, 5'($urandom)};
            y_before = m_y;
            tick();
            check($sformatf("reel_dy_%0d", i), 32'(reel_dy), 32'(reel_tab[i].exp_dy));
            check($sformatf("reel_y_%0d", i), 32'(fypos), 32'(y_before - reel_tab[i].exp_dy));
        end

        rise_until_landed();
        check("l1_level", 32'(level), 32'd1);
        check("l1_y", 32'(fypos), 32'd380);
        check("l1_vis", 32'(fish_vis), 32'd0);

        // Reach level 2, hook the fish, reel a little and reset mid-level.
        launch();
        catch_now();
        rise_until_landed();
        launch();
        catch_now();
        reel = {4'd11, 5'd0};
        repeat (3) tick();
        check("pre_rst_level", 32'(level), 32'd2);
        async_reset("mid_rst");
        tick();

        // Full run through all four levels to the win state, then restart.
        for (int l = 0; l < 4; l++) begin
            launch();
            catch_now();
            rise_until_landed();
        end
        check("win_flag", 32'(win), 32'd1);
        move = 1'b0;
        tick();
        check("win_hold", 32'(win), 32'd1);
        move = 1'b1;
        tick();
        check("restart_level", 32'(level), 32'd0);
        check("restart_win", 32'(win), 32'd0);

        // Randomized play with hooks biased around the fish.
        for (int t = 0; t < 6000; t++) begin
            move   = ($urandom_range(0, 7) != 0);
            grab   = ($urandom_range(0, 2) == 0);
            reel   = 9'($urandom);
            hook_x = 10'(m_x + int'($urandom_range(0, 19)) - 2);
            hook_y = 10'(m_y + int'($urandom_range(0, 26)) - 13);
            if ($urandom_range(0, 1499) == 0)
                async_reset("rand_rst");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fish_scheduler.md
# fish_scheduler

Game-tick sequencer for the fishing scene. It arms and launches each fish, sweeps it across the water, and detects a hook catch against the hook position. It then drives the hooked fish up with the reel input and advances through four levels to a win state. It sits between the player/line controller, which owns the rod and hook position, and the pixel renderer, which consumes fish geometry and the state flags.

## Interface
- ARM_TICKS, 400: player-movement ticks required before a fish launches
- SWIM_STEP, 2: fish x decrement per tick while swimming
- X_START, 798: fish spawn x (off right edge)
- X_END, 144: fish x at which the sweep restarts
- SURFACE_Y, 106: fish y below which a hooked fish counts as landed
- clk  in  1  game tick clock (slow, one update per tick)
- rst  in  1  reset, asynchronous, active-high
- move  in  1  player left or right pressed this tick
- grab  in  1  player up (hook-set) pressed
- reel  in  9  reel sensor magnitude; only reel[8:5] is used
- hook_x  in  10  hook line x
- hook_y  in  10  hook line tip y
- fxpos  out  10  fish left edge x
- fypos  out  10  fish centre y
- fish_w  out  6  fish width for current level
- fish_hh  out  4  fish half-height for current level
- level  out  2  current level 0..3
- fish_vis  out  1  fish drawable (SWIM or HOOKED)
- hooked  out  1  state == HOOKED
- reel_dy  out  2  pixels the line tip must rise this tick (0/1/2)
- win  out  1  state == WIN

## Operation
- States: ARM, SWIM, HOOKED, WIN. Reset values: ARM, level 0, arm_cnt 0, fxpos X_START, fypos 470, all flags 0, reel_dy 0.
- Level table (y, width, half-height, catch window): L0 470/60/10/15, L1 380/40/8/10, L2 290/20/5/5, L3 200/10/3/3.
- ARM:
  - fxpos held at X_START; fypos = level y.
  - arm_cnt increments on ticks with move=1 and saturates at ARM_TICKS.
  - When arm_cnt == ARM_TICKS, go to SWIM.
- SWIM:
  - fxpos -= SWIM_STEP per tick.
  - If fxpos == X_END: fxpos <= X_START, arm_cnt <= 0, go to ARM.
  - Catch check: grab && hook_x in [fxpos, fxpos+window] && hook_y in [fypos-hh, fypos+hh], all inclusive, using registered values. On a catch, go to HOOKED. The catch takes priority over the X_END wrap in the same tick.
- HOOKED:
  - fxpos <= hook_x every tick.
  - Rise rate: r = reel[8:5]; reel_dy = 2 if r > 9, 1 if r == 9, else 0. fypos -= reel_dy.
  - If the registered fypos < SURFACE_Y, land instead of moving the fish:
    - level < 3: level+1, fxpos X_START, fypos next level y, arm_cnt 0, go to ARM.
    - level == 3: go to WIN.
- WIN:
  - reel_dy 0, fish_vis 0.
  - On move: level 0, fypos 470, fxpos X_START, arm_cnt 0, go to ARM.
- reel_dy is 0 in every state except HOOKED.
- Arithmetic is 10-bit unsigned. Window bounds are computed in 11 bits so that fxpos+window and fypos+hh cannot wrap. fypos-hh floors at 0.

## Timing
- All outputs are registered and change only on the clk edge (or asynchronously on rst).
- A condition sampled at tick N produces its new state and outputs at tick N+1.
- The landing compare uses the pre-decrement fypos, so one extra rise tick occurs after crossing the surface.
- Reset asserted mid-level returns immediately to the reset values above; nothing is preserved.

## Structure
- Shared package fish_pkg holds:
  - the state enum,
  - the level table constants (y, width, half-height, window),
  - the reel rate thresholds (9),
  - the default X_START, X_END and SURFACE_Y values.
- One sub-module, fish_level_rom: combinational, level[1:0] to {y, w, hh, window}.
- The FSM, counters and catch compare stay in fish_scheduler.

## Test plan
- Reset, then 400 ticks with move=1 -> SWIM on tick 401, fxpos 798 then 796, 794, ...
- In SWIM with grab=0 -> fxpos reaches 144, then reloads to 798, state ARM, arm_cnt 0.
- L0 with fxpos=500, fypos=470, hook_x=510, hook_y=465, grab=1 -> HOOKED next tick, fxpos=510. Same stimulus with hook_x=516 -> no catch.
- HOOKED with reel[8:5]=10, then 9, then 8 -> reel_dy 2, 1, 0 and fypos drops by 2, 1, 0.
- Hooked fish rises through y=105 at L0 -> level 1, fypos 380, state ARM. The same sequence at L3 -> WIN, win=1. Then move=1 -> level 0, ARM.
- rst asserted while HOOKED at level 2 -> state ARM, level 0, fypos 470, fxpos 798 immediately.
